// File: rtl/pd_pkg.sv
// rtl/pd_pkg.sv - shared Prisoner's Dilemma decision codes, strategy codes and FSM states
//
// Purpose : common definitions used by strategy_player and the payoff calculator.
//   DEC_*   : decision encoding (0 = cooperate, 1 = defect)
//   STRAT_* : 3-bit strategy selector codes
//   pd_state_t : 2-bit per-round FSM encoding (IDLE / DECIDE / WAIT_OPP)
package pd_pkg;

  localparam logic DEC_COOP   = 1'b0;
  localparam logic DEC_DEFECT = 1'b1;

  localparam logic [2:0] STRAT_ALWAYS_COOP   = 3'd0;
  localparam logic [2:0] STRAT_ALWAYS_DEFECT = 3'd1;
  localparam logic [2:0] STRAT_TIT_FOR_TAT   = 3'd2;
  localparam logic [2:0] STRAT_GRUDGER       = 3'd3;
  localparam logic [2:0] STRAT_TIT_FOR_2TATS = 3'd4;
  localparam logic [2:0] STRAT_PAVLOV        = 3'd5;
  localparam logic [2:0] STRAT_RANDOM        = 3'd6;
  localparam logic [2:0] STRAT_RESERVED      = 3'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DECIDE   = 2'd1,
    WAIT_OPP = 2'd2
  } pd_state_t;

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1
//
// Purpose : pseudo-random bit source for the RANDOM strategy.
// Ports   : clk   in  1  clock, rising edge
//           rst_n in  1  synchronous active-low reset (loads SEED)
//           q     out 8  current LFSR state
// Params  : SEED  reset value; an all-zero seed would lock up, so it is replaced by 8'h01
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= SEED_EFF;
    end else begin
      // Taps at 8,6,5,4 -> bits 7,5,4,3; shift left, feedback into bit 0.
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

endmodule

// File: rtl/strategy_player.sv
// rtl/strategy_player.sv - one Prisoner's Dilemma player: strategy mux, opponent history, round FSM
//
// Purpose : on an accepted round_start emits one registered decision from the selected
//           strategy, then waits for the opponent's move and records it.
// Ports   : clk, rst_n (sync active-low), game_clear (sync clear of game state)
//           strategy_sel[2:0], round_start, opp_decision_valid, opp_decision  (inputs)
//           decision, decision_valid (1-cycle pulse), busy, round_count[7:0] (registered outputs)
// Config  : STRATEGY_LFSR_EN defined  -> strategy 6 uses bit 0 of a free-running LFSR
//           STRATEGY_LFSR_EN undefined -> strategy 6 behaves as tit-for-tat, no LFSR built
module strategy_player
  import pd_pkg::*;
#(
  parameter int         HIST_DEPTH = 8,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_clear,
  input  logic [2:0] strategy_sel,
  input  logic       round_start,
  input  logic       opp_decision_valid,
  input  logic       opp_decision,
  output logic       decision,
  output logic       decision_valid,
  output logic       busy,
  output logic [7:0] round_count
);

  pd_state_t             state;
  logic [HIST_DEPTH-1:0] history;
  logic                  grudge;
  logic                  last_own;
  logic                  first_round;
  logic                  rand_bit;
  logic                  next_dec;

`ifdef STRATEGY_LFSR_EN
  logic [7:0] lfsr_q;
  logic       unused_lfsr;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr8 (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  assign rand_bit    = lfsr_q[0];
  assign unused_lfsr = ^lfsr_q[7:1];
`else
  logic unused_seed;

  // Without the LFSR, RANDOM degrades to tit-for-tat.
  assign rand_bit    = first_round ? DEC_COOP : history[0];
  assign unused_seed = ^LFSR_SEED;
`endif

  assign first_round = (round_count == 8'd0);

  always_comb begin
    next_dec = DEC_COOP;
    case (strategy_sel)
      STRAT_ALWAYS_COOP:   next_dec = DEC_COOP;
      STRAT_ALWAYS_DEFECT: next_dec = DEC_DEFECT;
      STRAT_TIT_FOR_TAT:   next_dec = first_round ? DEC_COOP : history[0];
      STRAT_GRUDGER:       next_dec = grudge;
      STRAT_TIT_FOR_2TATS: next_dec = (round_count >= 8'd2) & history[0] & history[1];
      // Win-stay / lose-shift: switch own move after being defected on.
      STRAT_PAVLOV:        next_dec = first_round ? DEC_COOP : (history[0] ? ~last_own : last_own);
      STRAT_RANDOM:        next_dec = rand_bit;
      default:             next_dec = DEC_COOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || game_clear) begin
      // The LFSR is not cleared here; game_clear leaves it running.
      state          <= IDLE;
      decision       <= DEC_COOP;
      decision_valid <= 1'b0;
      busy           <= 1'b0;
      round_count    <= 8'd0;
      history        <= '0;
      grudge         <= 1'b0;
      last_own       <= 1'b0;
    end else begin
      decision_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (round_start) begin
            decision       <= next_dec;
            last_own       <= next_dec;
            decision_valid <= 1'b1;
            busy           <= 1'b1;
            state          <= DECIDE;
          end
        end
        DECIDE: begin
          state <= WAIT_OPP;
        end
        WAIT_OPP: begin
          // round_start arriving here is dropped; no request queueing.
          if (opp_decision_valid) begin
            history <= {history[HIST_DEPTH-2:0], opp_decision};
            grudge  <= grudge | opp_decision;
            if (round_count != 8'd255) begin
              round_count <= round_count + 8'd1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_strategy_player.sv
// tb/tb_strategy_player.sv - self-checking bench for strategy_player against a queue-based game model
module tb_strategy_player;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_clear = 1'b0;
  logic [2:0] strategy_sel = 3'd0;
  logic       round_start = 1'b0;
  logic       opp_decision_valid = 1'b0;
  logic       opp_decision = 1'b0;
  logic       decision;
  logic       decision_valid;
  logic       busy;
  logic [7:0] round_count;

  int tests = 0;
  int fails = 0;

  // Game record since last reset/clear: every opponent move and every own move, in order.
  logic opp_q[$];
  logic own_q[$];
  logic [7:0] m_lfsr;

  strategy_player #(
    .HIST_DEPTH (8),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .game_clear         (game_clear),
    .strategy_sel       (strategy_sel),
    .round_start        (round_start),
    .opp_decision_valid (opp_decision_valid),
    .opp_decision       (opp_decision),
    .decision           (decision),
    .decision_valid     (decision_valid),
    .busy               (busy),
    .round_count        (round_count)
  );

  always #5 clk = ~clk;

  // Reference random source: polynomial x^8+x^6+x^5+x^4+1, one step per clock after reset.
  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_dec(input logic [2:0] s);
    int   n;
    logic last_opp, prev_opp, ever_defected, own_last;
    n             = opp_q.size();
    last_opp      = (n > 0) ? opp_q[n-1] : 1'b0;
    prev_opp      = (n > 1) ? opp_q[n-2] : 1'b0;
    own_last      = (own_q.size() > 0) ? own_q[own_q.size()-1] : 1'b0;
    ever_defected = 1'b0;
    foreach (opp_q[i]) if (opp_q[i]) ever_defected = 1'b1;
    case (s)
      3'd0: return 1'b0;
      3'd1: return 1'b1;
      3'd2: return (n == 0) ? 1'b0 : last_opp;
      3'd3: return ever_defected;
      3'd4: return (n >= 2) && last_opp && prev_opp;
      3'd5: return (n == 0) ? 1'b0 : (last_opp ? ~own_last : own_last);
`ifdef STRATEGY_LFSR_EN
      3'd6: return m_lfsr[0];
`else
      3'd6: return (n == 0) ? 1'b0 : last_opp;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] model_count();
    return (opp_q.size() > 255) ? 8'd255 : 8'(opp_q.size());
  endfunction

  task automatic clear_model();
    opp_q.delete();
    own_q.delete();
  endtask

  // Issue round_start, check the decision pulse and the following cycle.
  task automatic start_round(input logic [2:0] s, input string tag);
    logic exp;
    exp          = model_dec(s);
    strategy_sel = s;
    round_start  = 1'b1;
    @(posedge clk); #1;
    round_start  = 1'b0;
    strategy_sel = 3'($urandom_range(0, 7));
    chk({tag, "_valid"}, 8'(decision_valid), 8'd1);
    chk({tag, "_dec"}, 8'(decision), 8'(exp));
    chk({tag, "_busy"}, 8'(busy), 8'd1);
    own_q.push_back(exp);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 8'(decision_valid), 8'd0);
  endtask

  task automatic finish_round(input logic o, input string tag);
    opp_decision_valid = 1'b1;
    opp_decision       = o;
    @(posedge clk); #1;
    opp_decision_valid = 1'b0;
    opp_q.push_back(o);
    chk({tag, "_idle"}, 8'(busy), 8'd0);
    chk({tag, "_count"}, round_count, model_count());
  endtask

  task automatic play(input logic [2:0] s, input logic o, input string tag);
    start_round(s, tag);
    finish_round(o, tag);
  endtask

  task automatic do_clear();
    game_clear = 1'b1;
    @(posedge clk); #1;
    game_clear = 1'b0;
    clear_model();
  endtask

  initial begin
    logic [3:0] tft_opp   = 4'b0110;
    logic [4:0] grudg_opp = 5'b00100;
    logic [3:0] t2t_opp   = 4'b1101;
    logic [2:0] pav_opp   = 3'b011;

    // Reset held two cycles with round_start asserted: nothing may start.
    round_start = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_valid", 8'(decision_valid), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
    end
    chk("rst_dec", 8'(decision), 8'd0);
    chk("rst_count", round_count, 8'd0);
    round_start = 1'b0;
    rst_n       = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 8'(decision_valid), 8'd0);

    // Tit-for-tat: opp 0,1,1,0 -> 0,0,1,1
    for (int i = 0; i < 4; i++) play(3'd2, tft_opp[i], $sformatf("tft%0d", i));
    do_clear();
    // Grudger: opp 0,0,1,0,0 -> 0,0,0,1,1
    for (int i = 0; i < 5; i++) play(3'd3, grudg_opp[i], $sformatf("grudger%0d", i));
    do_clear();
    // Tit-for-two-tats: opp 1,0,1,1 -> 0,0,0,0 then 1
    for (int i = 0; i < 4; i++) play(3'd4, t2t_opp[i], $sformatf("t2t%0d", i));
    play(3'd4, 1'b0, "t2t4");
    do_clear();
    // Pavlov: opp 1,1,0 -> 0,1,0,0
    for (int i = 0; i < 3; i++) play(3'd5, pav_opp[i], $sformatf("pavlov%0d", i));
    play(3'd5, 1'b0, "pavlov3");
    for (int i = 0; i < 3; i++) play(3'd1, 1'($urandom), $sformatf("defect%0d", i));

    // round_start while busy is ignored
    start_round(3'd0, "busy_rs");
    round_start = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("busy_rs_ignored", 8'(decision_valid), 8'd0);
    end
    round_start = 1'b0;
    finish_round(1'b0, "busy_rs");

    // opp move in IDLE is ignored
    opp_decision_valid = 1'b1;
    opp_decision       = 1'b1;
    @(posedge clk); #1;
    opp_decision_valid = 1'b0;
    chk("idle_opp_count", round_count, model_count());
    chk("idle_opp_busy", 8'(busy), 8'd0);

    // opp move and round_start together in WAIT_OPP: move taken, request dropped
    start_round(3'd2, "both");
    round_start        = 1'b1;
    opp_decision_valid = 1'b1;
    opp_decision       = 1'b1;
    @(posedge clk); #1;
    round_start        = 1'b0;
    opp_decision_valid = 1'b0;
    opp_q.push_back(1'b1);
    chk("both_count", round_count, model_count());
    chk("both_busy", 8'(busy), 8'd0);
    @(posedge clk); #1;
    chk("both_no_dec", 8'(decision_valid), 8'd0);

    // game_clear in WAIT_OPP after the opponent has defected
    play(3'd3, 1'b1, "pre_clear");
    start_round(3'd3, "clr");
    do_clear();
    chk("clr_busy", 8'(busy), 8'd0);
    chk("clr_count", round_count, 8'd0);
    chk("clr_valid", 8'(decision_valid), 8'd0);
    chk("clr_dec", 8'(decision), 8'd0);
    play(3'd3, 1'b0, "clr_grudge");

    // Strategy 6 over 8 rounds
    do_clear();
    for (int i = 0; i < 8; i++) play(3'd6, 1'($urandom), $sformatf("rand%0d", i));

    // Randomized mixed play with idle gaps
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      play(3'($urandom_range(0, 7)), 1'($urandom), $sformatf("mix%0d", i));
    end

    // Saturation of the round counter
    do_clear();
    for (int i = 0; i < 258; i++) play(3'($urandom_range(0, 7)), 1'($urandom), "sat");
    chk("sat_255", round_count, 8'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
